// File: rtl/atc_pkg.sv
// Shared types and constants for the runway scheduler: runway/gate/fuel codes,
// request FSM states and default timing values.
package atc_pkg;

  typedef logic [1:0] rwy_t;
  typedef logic [2:0] gate_t;
  typedef logic [1:0] fuel_t;
  typedef logic [3:0] cnt_t;

  localparam rwy_t RWY_NONE = 2'b00;
  localparam rwy_t RWY1     = 2'b01;
  localparam rwy_t RWY2     = 2'b10;

  localparam gate_t GATE_NONE     = 3'd0;
  localparam gate_t R1_GATE_FIRST = 3'd1;
  localparam gate_t R1_GATE_LAST  = 3'd3;
  localparam gate_t R2_GATE_FIRST = 3'd4;
  localparam gate_t R2_GATE_LAST  = 3'd6;

  localparam fuel_t FUEL_CRIT   = 2'b00;
  localparam fuel_t FUEL_EXCESS = 2'b11;

  localparam int unsigned DEF_OCCUPY    = 8;
  localparam int unsigned DEF_WX_HOLD   = 12;
  localparam int unsigned DEF_FUEL_HOLD = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } req_state_e;

  // Rotating gate pointer: wraps from the last gate of a runway back to its first.
  function automatic gate_t next_gate(input gate_t g, input gate_t first, input gate_t last);
    return (g == last) ? first : g + gate_t'(1);
  endfunction

endpackage

// File: rtl/runway_scheduler_if.sv
// Request/grant bundle between approach/ground request logic (master)
// and the runway scheduler (slave).
interface runway_scheduler_if;
  import atc_pkg::*;

  logic  weather_ok;
  logic  land_req;
  logic  land_emerg;
  fuel_t land_fuel;
  logic  to_req;
  gate_t to_gate;

  logic       land_grant;
  logic       to_grant;
  rwy_t       grant_rwy;
  gate_t      grant_gate;
  logic       to_err;
  cnt_t       land_hold_cnt;
  cnt_t       to_hold_cnt;
  logic [1:0] rwy_busy;

  modport master (
    output weather_ok, land_req, land_emerg, land_fuel, to_req, to_gate,
    input  land_grant, to_grant, grant_rwy, grant_gate, to_err,
           land_hold_cnt, to_hold_cnt, rwy_busy
  );

  modport slave (
    input  weather_ok, land_req, land_emerg, land_fuel, to_req, to_gate,
    output land_grant, to_grant, grant_rwy, grant_gate, to_err,
           land_hold_cnt, to_hold_cnt, rwy_busy
  );

endinterface

// File: rtl/runway_occupancy_timer.sv
// Per-runway occupancy down-counter: a load arms OCCUPY_CYCLES, the runway
// reads busy while the count is nonzero.
module runway_occupancy_timer
  import atc_pkg::*;
#(
  parameter int unsigned OCCUPY_CYCLES = DEF_OCCUPY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy,
  output cnt_t count
);

  localparam cnt_t LOAD_VAL = cnt_t'(OCCUPY_CYCLES);

  cnt_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign busy  = (count_q != '0);

endmodule

// File: rtl/runway_scheduler.sv
// Shares two runways between one landing and one takeoff requester, applying
// weather/fuel holds, fixed-priority arbitration and rotating gate assignment.
//
// state | meaning
// IDLE  | no request accepted (also the grant cycle)
// HOLD  | request accepted, hold counter running down
// WAIT  | request eligible for arbitration, waiting for a runway
module runway_scheduler
  import atc_pkg::*;
#(
  parameter int unsigned OCCUPY_CYCLES = DEF_OCCUPY,
  parameter int unsigned WX_HOLD       = DEF_WX_HOLD,
  parameter int unsigned FUEL_HOLD     = DEF_FUEL_HOLD
) (
  input logic               clk,
  input logic               rst_n,
  runway_scheduler_if.slave bus
);

  localparam cnt_t WX_LOAD   = cnt_t'(WX_HOLD);
  localparam cnt_t FUEL_LOAD = cnt_t'(FUEL_HOLD);

  req_state_e land_st_q, land_st_d;
  req_state_e to_st_q, to_st_d;
  cnt_t       land_hold_q, land_hold_d;
  cnt_t       to_hold_q, to_hold_d;
  logic       land_emg_q, land_emg_d;
  logic       to_rwy2_q, to_rwy2_d;
  gate_t      ptr1_q, ptr1_d;
  gate_t      ptr2_q, ptr2_d;
  logic       land_grant_q, land_grant_d;
  logic       to_grant_q, to_grant_d;
  logic       to_err_q, to_err_d;
  rwy_t       grant_rwy_q, grant_rwy_d;
  gate_t      grant_gate_q, grant_gate_d;

  logic busy1, busy2, load1, load2;
  cnt_t occ1, occ2;
  logic free1, free2, land_win, land_emg_now, to_win, to_gate_bad;

  runway_occupancy_timer #(.OCCUPY_CYCLES(OCCUPY_CYCLES)) u_occ_r1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .busy(busy1), .count(occ1)
  );

  runway_occupancy_timer #(.OCCUPY_CYCLES(OCCUPY_CYCLES)) u_occ_r2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .busy(busy2), .count(occ2)
  );

  // A takeoff yields to any eligible landing, even one headed for the other runway.
  always_comb begin
    free1        = (occ1 == '0);
    free2        = (occ2 == '0);
    land_emg_now = land_emg_q | bus.land_emerg;
    land_win     = (land_st_q == ST_WAIT) && bus.land_req && (free1 || free2);
    to_win       = (to_st_q == ST_WAIT) && bus.to_req && !land_win &&
                   (to_rwy2_q ? free2 : free1);
    load1        = (land_win && free1) || (to_win && !to_rwy2_q);
    load2        = (land_win && !free1) || (to_win && to_rwy2_q);

    land_grant_d = land_win;
    to_grant_d   = to_win;
    grant_rwy_d  = RWY_NONE;
    grant_gate_d = GATE_NONE;
    ptr1_d       = ptr1_q;
    ptr2_d       = ptr2_q;

    if (land_win) begin
      grant_rwy_d = free1 ? RWY1 : RWY2;
      if (!land_emg_now) begin
        if (free1) begin
          grant_gate_d = ptr1_q;
          ptr1_d       = next_gate(ptr1_q, R1_GATE_FIRST, R1_GATE_LAST);
        end else begin
          grant_gate_d = ptr2_q;
          ptr2_d       = next_gate(ptr2_q, R2_GATE_FIRST, R2_GATE_LAST);
        end
      end
    end else if (to_win) begin
      grant_rwy_d = to_rwy2_q ? RWY2 : RWY1;
    end
  end

  always_comb begin
    land_st_d   = land_st_q;
    land_hold_d = land_hold_q;
    land_emg_d  = land_emg_q;

    unique case (land_st_q)
      ST_IDLE: begin
        if (bus.land_req) begin
          if (bus.land_emerg || (bus.land_fuel == FUEL_CRIT)) begin
            land_st_d  = ST_WAIT;
            land_emg_d = 1'b1;
          end else if (!bus.weather_ok) begin
            land_st_d   = ST_HOLD;
            land_hold_d = WX_LOAD;
          end else if (bus.land_fuel == FUEL_EXCESS) begin
            land_st_d   = ST_HOLD;
            land_hold_d = FUEL_LOAD;
          end else begin
            land_st_d = ST_WAIT;
          end
        end
      end
      ST_HOLD: begin
        if (!bus.land_req) begin
          land_st_d   = ST_IDLE;
          land_hold_d = '0;
          land_emg_d  = 1'b0;
        end else if (bus.land_emerg) begin
          land_st_d   = ST_WAIT;
          land_hold_d = '0;
          land_emg_d  = 1'b1;
        end else if (land_hold_q <= cnt_t'(1)) begin
          land_st_d   = ST_WAIT;
          land_hold_d = '0;
        end else begin
          land_hold_d = land_hold_q - cnt_t'(1);
        end
      end
      ST_WAIT: begin
        if (!bus.land_req || land_win) begin
          land_st_d  = ST_IDLE;
          land_emg_d = 1'b0;
        end else if (bus.land_emerg) begin
          land_emg_d = 1'b1;
        end
      end
      default: begin
        land_st_d   = ST_IDLE;
        land_hold_d = '0;
        land_emg_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    to_st_d     = to_st_q;
    to_hold_d   = to_hold_q;
    to_rwy2_d   = to_rwy2_q;
    to_err_d    = 1'b0;
    to_gate_bad = (bus.to_gate < R1_GATE_FIRST) || (bus.to_gate > R2_GATE_LAST);

    unique case (to_st_q)
      ST_IDLE: begin
        if (bus.to_req) begin
          if (to_gate_bad) begin
            to_err_d = 1'b1;
          end else begin
            to_rwy2_d = (bus.to_gate >= R2_GATE_FIRST);
            if (!bus.weather_ok) begin
              to_st_d   = ST_HOLD;
              to_hold_d = FUEL_LOAD;
            end else begin
              to_st_d = ST_WAIT;
            end
          end
        end
      end
      ST_HOLD: begin
        if (!bus.to_req) begin
          to_st_d   = ST_IDLE;
          to_hold_d = '0;
        end else if (to_hold_q <= cnt_t'(1)) begin
          to_st_d   = ST_WAIT;
          to_hold_d = '0;
        end else begin
          to_hold_d = to_hold_q - cnt_t'(1);
        end
      end
      ST_WAIT: begin
        if (!bus.to_req || to_win) begin
          to_st_d = ST_IDLE;
        end
      end
      default: begin
        to_st_d   = ST_IDLE;
        to_hold_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      land_st_q    <= ST_IDLE;
      to_st_q      <= ST_IDLE;
      land_hold_q  <= '0;
      to_hold_q    <= '0;
      land_emg_q   <= 1'b0;
      to_rwy2_q    <= 1'b0;
      ptr1_q       <= R1_GATE_FIRST;
      ptr2_q       <= R2_GATE_FIRST;
      land_grant_q <= 1'b0;
      to_grant_q   <= 1'b0;
      to_err_q     <= 1'b0;
      grant_rwy_q  <= RWY_NONE;
      grant_gate_q <= GATE_NONE;
    end else begin
      land_st_q    <= land_st_d;
      to_st_q      <= to_st_d;
      land_hold_q  <= land_hold_d;
      to_hold_q    <= to_hold_d;
      land_emg_q   <= land_emg_d;
      to_rwy2_q    <= to_rwy2_d;
      ptr1_q       <= ptr1_d;
      ptr2_q       <= ptr2_d;
      land_grant_q <= land_grant_d;
      to_grant_q   <= to_grant_d;
      to_err_q     <= to_err_d;
      grant_rwy_q  <= grant_rwy_d;
      grant_gate_q <= grant_gate_d;
    end
  end

  assign bus.land_grant    = land_grant_q;
  assign bus.to_grant      = to_grant_q;
  assign bus.grant_rwy     = grant_rwy_q;
  assign bus.grant_gate    = grant_gate_q;
  assign bus.to_err        = to_err_q;
  assign bus.land_hold_cnt = land_hold_q;
  assign bus.to_hold_cnt   = to_hold_q;
  assign bus.rwy_busy      = {busy2, busy1};

endmodule

// File: tb/tb_runway_scheduler.sv
// Bench for runway_scheduler: directed scenarios plus randomized traffic, every
// cycle compared against a reference model built on runway free-times and gate indices.
module tb_runway_scheduler;
  import atc_pkg::*;

  localparam int OCC = 8;
  localparam int WX  = 12;
  localparam int FH  = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  runway_scheduler_if bus();

  runway_scheduler #(.OCCUPY_CYCLES(OCC), .WX_HOLD(WX), .FUEL_HOLD(FH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks;
  int n_errors;
  int lat;

  // Reference model: runways free from an absolute cycle number, gates as index 0..2
  int m_cycle;
  int free_at [1:2];
  int ptr_idx [1:2];
  bit l_act, l_emg, t_act;
  int l_hold, t_hold, t_rwy;
  bit e_lg, e_tg, e_err;
  int e_rwy, e_gate;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cycle = 0;
    free_at[1] = 0; free_at[2] = 0;
    ptr_idx[1] = 0; ptr_idx[2] = 0;
    l_act = 0; l_emg = 0; l_hold = 0;
    t_act = 0; t_hold = 0; t_rwy = 1;
    e_lg = 0; e_tg = 0; e_err = 0; e_rwy = 0; e_gate = 0;
  endtask

  task automatic model_step();
    bit f1, f2, l_can, t_can, emg_now, bad_gate;
    int r;
    f1 = (m_cycle >= free_at[1]);
    f2 = (m_cycle >= free_at[2]);
    l_can = l_act && (l_hold == 0) && bus.land_req && (f1 || f2);
    t_can = t_act && (t_hold == 0) && bus.to_req && (m_cycle >= free_at[t_rwy]) && !l_can;
    emg_now = l_emg || bus.land_emerg;
    bad_gate = (bus.to_gate == 0) || (bus.to_gate == 7);
    e_lg = l_can; e_tg = t_can; e_rwy = 0; e_gate = 0;
    e_err = !t_act && bus.to_req && bad_gate;
    if (l_can) begin
      r = f1 ? 1 : 2;
      e_rwy = r;
      free_at[r] = m_cycle + 1 + OCC;
      if (!emg_now) begin
        e_gate = ((r == 1) ? 1 : 4) + ptr_idx[r];
        ptr_idx[r] = (ptr_idx[r] + 1) % 3;
      end
    end else if (t_can) begin
      e_rwy = t_rwy;
      free_at[t_rwy] = m_cycle + 1 + OCC;
    end

    if (!l_act) begin
      if (bus.land_req) begin
        l_act = 1;
        l_emg = bus.land_emerg || (bus.land_fuel == 2'b00);
        if (l_emg) l_hold = 0;
        else if (!bus.weather_ok) l_hold = WX;
        else if (bus.land_fuel == 2'b11) l_hold = FH;
        else l_hold = 0;
      end
    end else if (!bus.land_req || l_can) begin
      l_act = 0; l_emg = 0; l_hold = 0;
    end else if (bus.land_emerg) begin
      l_emg = 1; l_hold = 0;
    end else if (l_hold > 0) begin
      l_hold--;
    end

    if (!t_act) begin
      if (bus.to_req && !bad_gate) begin
        t_act = 1;
        t_rwy = (bus.to_gate >= 4) ? 2 : 1;
        t_hold = bus.weather_ok ? 0 : FH;
      end
    end else if (!bus.to_req || t_can) begin
      t_act = 0; t_hold = 0;
    end else if (t_hold > 0) begin
      t_hold--;
    end
    m_cycle++;
  endtask

  task automatic compare_all();
    logic [1:0] busy_exp;
    busy_exp = {m_cycle < free_at[2], m_cycle < free_at[1]};
    chk("land_grant", bus.land_grant, e_lg);
    chk("to_grant", bus.to_grant, e_tg);
    chk("grant_rwy", bus.grant_rwy, e_rwy);
    chk("grant_gate", bus.grant_gate, e_gate);
    chk("to_err", bus.to_err, e_err);
    chk("land_hold_cnt", bus.land_hold_cnt, l_hold);
    chk("to_hold_cnt", bus.to_hold_cnt, t_hold);
    chk("rwy_busy", bus.rwy_busy, busy_exp);
  endtask

  // One clock: model advances at the edge, outputs compared at the falling edge.
  // Requesters release their request once granted or rejected.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    compare_all();
    if (bus.land_grant) begin
      bus.land_req = 1'b0;
      bus.land_emerg = 1'b0;
    end
    if (bus.to_grant || bus.to_err) bus.to_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_land(input int budget);
    int n;
    n = 0;
    do begin
      tick(); lat++; n++;
    end while (!bus.land_grant && n < budget);
    if (!bus.land_grant) chk("land_timeout", 0, 1);
  endtask

  task automatic wait_to(input int budget);
    int n;
    n = 0;
    do begin
      tick(); lat++; n++;
    end while (!bus.to_grant && n < budget);
    if (!bus.to_grant) chk("to_timeout", 0, 1);
  endtask

  function automatic logic [17:0] all_outputs();
    return {bus.land_grant, bus.to_grant, bus.grant_rwy, bus.grant_gate, bus.to_err,
            bus.land_hold_cnt, bus.to_hold_cnt, bus.rwy_busy};
  endfunction

  task automatic random_cycle();
    if ($urandom_range(0, 15) == 0) bus.weather_ok = ~bus.weather_ok;
    if (!bus.land_req) begin
      if ($urandom_range(0, 5) == 0) begin
        bus.land_req = 1'b1;
        bus.land_fuel = 2'($urandom_range(0, 3));
        bus.land_emerg = ($urandom_range(0, 9) == 0);
      end
    end else begin
      bus.land_fuel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.land_emerg = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        bus.land_req = 1'b0;
        bus.land_emerg = 1'b0;
      end
    end
    if (!bus.to_req) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.to_req = 1'b1;
        bus.to_gate = 3'($urandom_range(0, 7));
      end
    end else begin
      bus.to_gate = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) bus.to_req = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.weather_ok = 1'b1;
    bus.land_req = 1'b0;
    bus.land_emerg = 1'b0;
    bus.land_fuel = 2'b01;
    bus.to_req = 1'b0;
    bus.to_gate = 3'd0;
    model_reset();
    ticks(2);
    chk("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;

    // Normal landing, then a second one on runway 1 after it frees
    bus.land_req = 1'b1; bus.land_fuel = 2'b01;
    lat = 0; wait_land(6);
    chk("l1_latency", lat, 2);
    chk("l1_rwy", bus.grant_rwy, 1);
    chk("l1_gate", bus.grant_gate, 1);
    ticks(OCC);
    bus.land_req = 1'b1;
    lat = 0; wait_land(6);
    chk("l2_rwy", bus.grant_rwy, 1);
    chk("l2_gate", bus.grant_gate, 2);
    ticks(10);

    // Weather hold; weather recovering mid-hold does not shorten it
    bus.weather_ok = 1'b0; bus.land_req = 1'b1; bus.land_fuel = 2'b10;
    lat = 0; ticks(3); lat = 3;
    bus.weather_ok = 1'b1;
    wait_land(20);
    chk("wx_latency", lat, WX + 2);
    chk("wx_rwy", bus.grant_rwy, 1);
    ticks(10);

    // Excess-fuel hold interrupted by an emergency at count 9
    bus.land_req = 1'b1; bus.land_fuel = 2'b11;
    for (int i = 0; i < 20 && bus.land_hold_cnt != 4'd9; i++) tick();
    chk("fuel_hold_at9", bus.land_hold_cnt, 9);
    bus.land_emerg = 1'b1;
    lat = 0; wait_land(4);
    chk("emg_latency", lat, 2);
    chk("emg_gate", bus.grant_gate, 0);
    chk("emg_rwy", bus.grant_rwy, 1);
    ticks(10);
    bus.land_req = 1'b1; bus.land_fuel = 2'b01;
    lat = 0; wait_land(6);
    chk("ptr_kept_gate", bus.grant_gate, 1);

    // Runway 1 busy: landing and takeoff to gate 5 together
    bus.land_req = 1'b1; bus.land_fuel = 2'b01;
    bus.to_req = 1'b1; bus.to_gate = 3'd5;
    lat = 0; wait_land(6);
    chk("race_land_rwy", bus.grant_rwy, 2);
    chk("race_land_gate", bus.grant_gate, 4);
    chk("race_to_lost", bus.to_grant, 0);
    lat = 0; wait_to(20);
    chk("race_to_rwy", bus.grant_rwy, 2);
    chk("race_to_gate", bus.grant_gate, 0);
    ticks(12);

    // Invalid gate, then a weather-held takeoff to gate 2
    bus.to_req = 1'b1; bus.to_gate = 3'd0;
    tick();
    chk("err_pulse", bus.to_err, 1);
    tick();
    chk("err_cleared", bus.to_err, 0);
    bus.weather_ok = 1'b0; bus.to_req = 1'b1; bus.to_gate = 3'd2;
    lat = 0; tick(); lat = 1;
    chk("to_hold_load", bus.to_hold_cnt, FH);
    bus.weather_ok = 1'b1;
    wait_to(25);
    chk("to_latency", lat, FH + 2);
    chk("to_rwy", bus.grant_rwy, 1);
    ticks(12);

    // Reset in the middle of a landing hold
    bus.weather_ok = 1'b0; bus.land_req = 1'b1; bus.land_fuel = 2'b01;
    ticks(4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hold", all_outputs(), 0);
    model_reset();
    bus.land_req = 1'b0; bus.weather_ok = 1'b1;
    ticks(2);
    rst_n = 1'b1;
    chk("rst_busy", bus.rwy_busy, 0);
    bus.land_req = 1'b1;
    lat = 0; wait_land(6);
    chk("rst_r1_gate", bus.grant_gate, 1);
    bus.land_req = 1'b1;
    lat = 0; wait_land(6);
    chk("rst_r2_rwy", bus.grant_rwy, 2);
    chk("rst_r2_gate", bus.grant_gate, 4);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      random_cycle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
